sdram_axi_arbiter: RTL and testbench

- Shares the single AXI-style port of sdram_controller between NUM_REQ requesters.
- Requester channels: AR/R/AW/W, no B channel.
- Round-robin grant, one transaction at a time on the downstream address channels.
- Routes read data back to the issuing requester using an in-order FIFO of requester IDs; the controller returns reads in issue order.
- Sits between user logic (DMA, CPU bridge) and sdram_controller's s_axi_* ports.

---
 rtl/sdram_axi_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sdram_axi_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_axi_arbiter.sv
// Shares one sdram_controller AXI-style port between NUM_REQ requesters; reads routed back via an in-order ID FIFO.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sdram_axi_arbiter #(
    parameter int ADDR_WIDTH      = 25,
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic [NUM_REQ-1:0]               s_axi_arvalid,
    output logic [NUM_REQ-1:0]               s_axi_arready,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    s_axi_rdata,
    output logic [NUM_REQ-1:0]               s_axi_rvalid,
    input  logic [NUM_REQ-1:0]               s_axi_rready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic [NUM_REQ-1:0]               s_axi_awvalid,
    output logic [NUM_REQ-1:0]               s_axi_awready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_axi_wdata,
    input  logic [NUM_REQ-1:0]               s_axi_wvalid,
    output logic [NUM_REQ-1:0]               s_axi_wready,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready,
    output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
    output logic                             m_axi_awvalid,
    input  logic                             m_axi_awready,
    output logic [DATA_WIDTH-1:0]            m_axi_wdata,
    output logic                             m_axi_wvalid,
    input  logic                             m_axi_wready,
    output logic [$clog2(MAX_OUTSTANDING):0] rd_outstanding,
    output logic                             err_unexpected_r
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE_RD, ISSUE_WR} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   grant;
    logic             aw_done, w_done;
    logic             push, pop, wr_fin, spurious;
    logic             aw_ok, w_ok;
    logic             full, empty;
    logic [IDW-1:0]   head;
    logic [IDW-1:0]   fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [NUM_REQ-1:0] rd_pend, wr_pend;
    logic             win_found, win_wr;
    logic [IDW-1:0]   win_idx;
    int               idx;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]   rr_ptr;
`endif

    assign empty          = (count == '0);
    assign full           = (count == CW'(MAX_OUTSTANDING));
    assign rd_outstanding = count;
    assign rd_pend        = s_axi_arvalid & {NUM_REQ{~full}};
    assign wr_pend        = s_axi_awvalid & s_axi_wvalid;
    assign s_axi_rdata    = {NUM_REQ{m_axi_rdata}};

    // Winner search; a requester's write beats its own read.
    always_comb begin
        win_found = 1'b0;
        win_wr    = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(rr_ptr) + 1 + k) % NUM_REQ;
`endif
            if (!win_found && (wr_pend[idx] || rd_pend[idx])) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
                win_wr    = wr_pend[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        m_axi_arvalid = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axi_arready = '0;
        s_axi_awready = '0;
        s_axi_wready  = '0;
        push          = 1'b0;
        wr_fin        = 1'b0;
        aw_ok         = aw_done | m_axi_awready;
        w_ok          = w_done | m_axi_wready;
        m_axi_araddr  = s_axi_araddr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_awaddr  = s_axi_awaddr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_wdata   = s_axi_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        case (state)
            IDLE: begin
                if (win_found) state_nxt = win_wr ? ISSUE_WR : ISSUE_RD;
            end
            ISSUE_RD: begin
                m_axi_arvalid        = 1'b1;
                s_axi_arready[grant] = m_axi_arready;
                if (m_axi_arready) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ISSUE_WR: begin
                // Each channel drops out independently once it has handshaken.
                m_axi_awvalid        = ~aw_done;
                m_axi_wvalid         = ~w_done;
                s_axi_awready[grant] = m_axi_awready & ~aw_done;
                s_axi_wready[grant]  = m_axi_wready & ~w_done;
                if (aw_ok && w_ok) begin
                    wr_fin    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // R routing: an R beat with no recorded issuer is swallowed and flagged.
    always_comb begin
        head                = fifo_mem[rd_ptr];
        s_axi_rvalid        = '0;
        s_axi_rvalid[head]  = m_axi_rvalid & ~empty;
        m_axi_rready        = empty ? 1'b1 : s_axi_rready[head];
        pop                 = m_axi_rvalid & m_axi_rready & ~empty;
        spurious            = m_axi_rvalid & empty;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            grant            <= '0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            err_unexpected_r <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            rr_ptr           <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            if (state == IDLE && win_found) grant <= win_idx;
            if (state == ISSUE_WR) begin
                if (wr_fin) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (m_axi_awready) aw_done <= 1'b1;
                    if (m_axi_wready)  w_done  <= 1'b1;
                end
            end
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            if (push || wr_fin) rr_ptr <= grant;
`endif
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (spurious) err_unexpected_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_axi_arbiter.sv
// Random + directed bench for sdram_axi_arbiter: requester tasks, a memory-backed downstream model and a per-requester R scoreboard.
module tb_sdram_axi_arbiter;
    localparam int AW = 25, DW = 16, NR = 2, MO = 4;

    logic clk = 1'b0, reset = 1'b0;
    logic [NR*AW-1:0] s_axi_araddr = '0, s_axi_awaddr = '0;
    logic [NR*DW-1:0] s_axi_wdata = '0, s_axi_rdata;
    logic [NR-1:0] s_axi_arvalid = '0, s_axi_awvalid = '0, s_axi_wvalid = '0, s_axi_rready = '1;
    logic [NR-1:0] s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid;
    logic [AW-1:0] m_axi_araddr, m_axi_awaddr;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata = '0;
    logic m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready;
    logic m_axi_arready = 1'b0, m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_rvalid = 1'b0;
    logic [$clog2(MO):0] rd_outstanding;
    logic err_unexpected_r;

    sdram_axi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .reset(reset),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .rd_outstanding(rd_outstanding), .err_unexpected_r(err_unexpected_r)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: memory as seen by requesters, and expected R data per requester in issue order.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] dn_mem  [logic [AW-1:0]];
    logic [DW-1:0] exp_q   [NR][$];
    logic [AW-1:0] ar_log[$];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction
    function automatic logic [DW-1:0] dn_rd(input logic [AW-1:0] a);
        return dn_mem.exists(a) ? dn_mem[a] : '0;
    endfunction

    // Downstream controller knobs
    int  pct = 100;
    bit  r_en = 1'b1, inject = 1'b0, chk_out = 1'b0;
    int  cyc = 0, last_aw_cyc = 0, last_ar_cyc = 0, rd_model = 0;

    initial begin
        logic [AW-1:0] awq[$], rq_a;
        logic [DW-1:0] wq[$], rq[$];
        logic [AW-1:0] ar_a, aw_a;
        logic [DW-1:0] w_d;
        bit ar_hs, aw_hs, w_hs, r_hs, rst_seen, r_from_q;
        r_from_q = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = m_axi_arvalid & m_axi_arready;
            aw_hs = m_axi_awvalid & m_axi_awready;
            w_hs  = m_axi_wvalid & m_axi_wready;
            r_hs  = m_axi_rvalid & m_axi_rready;
            ar_a = m_axi_araddr; aw_a = m_axi_awaddr; w_d = m_axi_wdata;
            rst_seen = !reset;
            if (chk_out) chk("rd_outstanding", rd_outstanding, rd_model);
            @(posedge clk);
            cyc++;
            #2;
            if (rst_seen) begin
                awq.delete(); wq.delete(); rq.delete();
                rd_model = 0; m_axi_rvalid = 1'b0; r_from_q = 1'b0;
            end else begin
                if (aw_hs) begin awq.push_back(aw_a); last_aw_cyc = cyc; end
                if (w_hs) wq.push_back(w_d);
                while (awq.size() > 0 && wq.size() > 0) begin
                    rq_a = awq.pop_front();
                    dn_mem[rq_a] = wq.pop_front();
                end
                if (ar_hs) begin
                    rq.push_back(dn_rd(ar_a)); ar_log.push_back(ar_a);
                    last_ar_cyc = cyc; rd_model++;
                end
                if (r_hs) begin
                    if (r_from_q) begin void'(rq.pop_front()); rd_model--; end
                    m_axi_rvalid = 1'b0; r_from_q = 1'b0;
                end
                if (!m_axi_rvalid) begin
                    if (inject) begin
                        m_axi_rvalid = 1'b1; m_axi_rdata = 16'hDEAD; inject = 1'b0;
                    end else if (r_en && rq.size() > 0 && ($urandom % 100) < pct) begin
                        m_axi_rvalid = 1'b1; m_axi_rdata = rq[0]; r_from_q = 1'b1;
                    end
                end
            end
            m_axi_arready = ($urandom % 100) < pct;
            m_axi_awready = ($urandom % 100) < pct;
            m_axi_wready  = ($urandom % 100) < pct;
        end
    end

    // R scoreboard: every beat delivered to a requester must match its oldest expected read.
    initial forever begin
        @(negedge clk);
        if (reset && s_axi_rvalid != '0) begin
            chk("r_onehot", $countones(s_axi_rvalid), 1);
            for (int r = 0; r < NR; r++)
                if (s_axi_rvalid[r] && s_axi_rready[r]) begin
                    if (exp_q[r].size() == 0) chk("r_unexpected", r, 99);
                    else chk("rdata", s_axi_rdata[r*DW +: DW], exp_q[r].pop_front());
                end
        end
    end

    task automatic rd_burst(input int r, input int n, input logic [AW-1:0] base);
        int to;
        logic [AW-1:0] a;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            a = base + AW'(k);
            s_axi_araddr[r*AW +: AW] = a;
            s_axi_arvalid[r] = 1'b1;
            to = 0;
            forever begin
                @(negedge clk);
                if (s_axi_arready[r]) break;
                if (++to > 300) begin
                    chk("ar_timeout", r, 99);
                    s_axi_arvalid[r] = 1'b0;
                    return;
                end
            end
            exp_q[r].push_back(ref_rd(a));
            @(posedge clk); #1;
        end
        s_axi_arvalid[r] = 1'b0;
    endtask

    task automatic wr(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit aw_ok, w_ok, aw_now, w_now;
        int to;
        aw_ok = 0; w_ok = 0; to = 0;
        @(posedge clk); #1;
        s_axi_awaddr[r*AW +: AW] = a;
        s_axi_wdata[r*DW +: DW] = d;
        s_axi_awvalid[r] = 1'b1;
        s_axi_wvalid[r] = 1'b1;
        while (!(aw_ok && w_ok)) begin
            @(negedge clk);
            aw_now = s_axi_awvalid[r] & s_axi_awready[r];
            w_now  = s_axi_wvalid[r] & s_axi_wready[r];
            @(posedge clk); #1;
            if (aw_now) begin s_axi_awvalid[r] = 1'b0; aw_ok = 1; end
            if (w_now)  begin s_axi_wvalid[r] = 1'b0;  w_ok = 1; end
            if (++to > 300) begin
                chk("wr_timeout", r, 99);
                s_axi_awvalid[r] = 1'b0; s_axi_wvalid[r] = 1'b0;
                return;
            end
        end
        ref_mem[a] = d;
    endtask

    task automatic drain();
        int to;
        to = 0;
        while ((rd_outstanding != 0 || exp_q[0].size() != 0 || exp_q[1].size() != 0) && to < 500) begin
            @(negedge clk); to++;
        end
        chk("drain", to < 500, 1);
        @(posedge clk); #1;
    endtask

    task automatic rand_traffic(input int r);
        logic [AW-1:0] a;
        for (int k = 0; k < 30; k++) begin
            a = (AW'(r) << 20) | AW'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) wr(r, a, DW'($urandom));
            else rd_burst(r, 1, a);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] la;
        int exp_id;
        // Reset with everything requesting
        s_axi_arvalid = '1; s_axi_awvalid = '1; s_axi_wvalid = '1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", s_axi_arready, 0);
        chk("rst_awready", s_axi_awready, 0);
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_m_valid", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 0);
        chk("rst_outstanding", rd_outstanding, 0);
        chk("rst_err", err_unexpected_r, 0);
        @(posedge clk); #1;
        s_axi_arvalid = '0; s_axi_awvalid = '0; s_axi_wvalid = '0;
        @(posedge clk); #1;
        reset = 1'b1; chk_out = 1'b1;

        // Req1 write then read-back, with latency checks
        pct = 0;
        fork
            wr(1, 25'h0001234, 16'hBEEF);
            begin
                @(posedge clk); #1;
                @(negedge clk); chk("aw_no_comb", m_axi_awvalid, 0);
                @(negedge clk); chk("aw_valid", m_axi_awvalid, 1);
                chk("awaddr", m_axi_awaddr, 25'h0001234);
                chk("wdata", m_axi_wdata, 16'hBEEF);
                pct = 100;
            end
        join
        r_en = 0;
        rd_burst(1, 1, 25'h0001234);
        @(negedge clk); chk("rdout_1", rd_outstanding, 1);
        r_en = 1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (s_axi_rvalid != '0) break;
        end
        chk("rvalid_req1", s_axi_rvalid, 2'b10);
        chk("rdata_req1", s_axi_rdata[31:16], 16'hBEEF);
        @(negedge clk); chk("rdout_0", rd_outstanding, 0);
        drain();

        // Both requesters stream 8 reads each
        ar_log.delete();
        fork
            rd_burst(0, 8, 25'h0000100);
            rd_burst(1, 8, 25'h0100100);
        join
        drain();
        chk("rr_count", ar_log.size(), 16);
        for (int k = 0; k < 16 && k < ar_log.size(); k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            exp_id = (k < 8) ? 0 : 1;
`else
            exp_id = k % 2;
`endif
            la = ar_log[k];
            chk("grant_order", la[20], exp_id);
        end

        // Same-cycle write and read from req0: write goes first
        fork
            wr(0, 25'h0000200, 16'h5A5A);
            rd_burst(0, 1, 25'h0000200);
        join
        drain();
        chk("write_first", last_aw_cyc < last_ar_cyc, 1);

        // Fill the read-ID FIFO, fifth read must stall until an R beat pops
        r_en = 0;
        rd_burst(0, MO, 25'h0000300);
        fork
            rd_burst(0, 1, 25'h0000304);
            begin
                @(posedge clk); #1;
                repeat (4) begin
                    @(negedge clk);
                    chk("full_arready", s_axi_arready[0], 0);
                    chk("full_m_arvalid", m_axi_arvalid, 0);
                end
                chk("full_outstanding", rd_outstanding, MO);
                r_en = 1;
            end
        join
        drain();

        // Randomized concurrent traffic
        pct = 60;
        fork
            rand_traffic(0);
            rand_traffic(1);
        join
        pct = 100;
        drain();
        chk("exp_empty", exp_q[0].size() + exp_q[1].size(), 0);

        // Spurious R beat with nothing outstanding
        inject = 1'b1;
        @(negedge clk);
        chk("spur_rvalid", s_axi_rvalid, 0);
        chk("spur_rready", m_axi_rready, 1);
        chk("spur_err_pre", err_unexpected_r, 0);
        @(negedge clk); chk("spur_err_set", err_unexpected_r, 1);
        repeat (5) @(negedge clk);
        chk("spur_err_hold", err_unexpected_r, 1);
        chk_out = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("spur_err_clr", err_unexpected_r, 0);
        chk("final_outstanding", rd_outstanding, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
